// File: rtl/front_panel_conditioner.sv
// -----------------------------------------------------------------------------
// front_panel_conditioner
//
// Conditions the raw front-panel switches and the manual-step pushbutton for
// the clock/clear selector. Every raw input is brought into the clock domain
// through a two-flop synchronizer. It is then debounced by a per-channel
// stability counter. A press of the debounced step button issues one
// fixed-width MAN_CLK pulse, but only while the panel is in manual mode, RUN
// is on and CLR is off. STEP_COUNT counts the pulses that were issued.
//
// Optional feature: define STEP_REPEAT_EN to enable auto-repeat while the step
// button is held. Without it the REPEAT_* parameters have no effect.
//
// Ports:
//   clock       system clock (single domain)
//   RST_N       synchronous active-low reset
//   RUN_SW      raw RUN switch (async)
//   CLR_SW      raw CLR switch (async)
//   A_M_SW      raw auto/manual switch (async), 1 = manual
//   STEP_BTN    raw manual-step button (async), 1 = pressed
//   RUN         debounced RUN level
//   CLR         debounced CLR level
//   A_M         debounced A/M level
//   MAN_CLK     conditioned manual clock pulse
//   STEP_COUNT  MAN_CLK pulses issued, modulo 256
// -----------------------------------------------------------------------------
module front_panel_conditioner #(
   parameter int DEBOUNCE_CYCLES  = 50000,
   parameter int CNT_W            = 16,
   parameter int STEP_HIGH_CYCLES = 1000,
   parameter int REPEAT_DELAY     = 25000000,
   parameter int REPEAT_PERIOD    = 5000000
) (
   input  logic       clock,
   input  logic       RST_N,
   input  logic       RUN_SW,
   input  logic       CLR_SW,
   input  logic       A_M_SW,
   input  logic       STEP_BTN,
   output logic       RUN,
   output logic       CLR,
   output logic       A_M,
   output logic       MAN_CLK,
   output logic [7:0] STEP_COUNT
);

   localparam int NCH    = 4;
   localparam int CH_RUN = 0;
   localparam int CH_CLR = 1;
   localparam int CH_AM  = 2;
   localparam int CH_BTN = 3;

   localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam int               PW      = (STEP_HIGH_CYCLES > 1) ? $clog2(STEP_HIGH_CYCLES) : 1;
   localparam logic [PW-1:0]    PULSE_LAST = PW'(STEP_HIGH_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PULSE    = 2'd1,
      WAIT_REL = 2'd2
   } step_state_t;

   // ---------------------------------------------------------------------------
   // Synchronizers and debouncers
   // ---------------------------------------------------------------------------
   logic [NCH-1:0]            raw;
   logic [NCH-1:0]            sync1;
   logic [NCH-1:0]            sync2;
   logic [NCH-1:0]            level;
   logic [NCH-1:0][CNT_W-1:0] db_cnt;

   assign raw = {STEP_BTN, A_M_SW, CLR_SW, RUN_SW};

   always_ff @(posedge clock) begin
      // NOTE: reset is sampled on the clock edge like any other input, so RST_N
      // stays out of the sensitivity list.
      if (!RST_N) begin
         sync1  <= '0;
         sync2  <= '0;
         level  <= '0;
         db_cnt <= '0;
      end else begin
         // NOTE: non-blocking assignments make sync2 take the pre-edge sync1,
         // which gives a real two-stage chain instead of a single flop.
         sync1 <= raw;
         sync2 <= sync1;
         for (int i = 0; i < NCH; i++) begin
            if (sync2[i] == level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               // DEBOUNCE_CYCLES consecutive differing samples: accept the new level
               level[i]  <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign RUN = level[CH_RUN];
   assign CLR = level[CH_CLR];
   assign A_M = level[CH_AM];

   logic btn_db, clr_db, btn_prev, clr_prev;
   logic press, clr_rise, gate;

   assign btn_db   = level[CH_BTN];
   assign clr_db   = level[CH_CLR];
   assign press    = btn_db & ~btn_prev;
   assign clr_rise = clr_db & ~clr_prev;
   assign gate     = level[CH_AM] & level[CH_RUN] & ~level[CH_CLR];

   // ---------------------------------------------------------------------------
   // Step FSM
   // ---------------------------------------------------------------------------
   step_state_t   state, next_state;
   logic [PW-1:0] pulse_cnt;
   logic          man_clk_next;
   logic          step_inc;

`ifdef STEP_REPEAT_EN
   localparam logic [31:0] REP_DELAY_LAST  = 32'(REPEAT_DELAY - 1);
   // Waiting time after a repeat pulse ends, so that pulses start REPEAT_PERIOD apart
   localparam logic [31:0] REP_PERIOD_LAST = 32'(REPEAT_PERIOD - STEP_HIGH_CYCLES - 1);

   logic [31:0] rep_cnt;
   logic        rep_stop;    // repeat is disallowed for the rest of this press
   logic        rep_active;  // the first repeat has already happened
   logic        rep_go;

   assign rep_go = gate && !rep_stop &&
                   (rep_cnt == (rep_active ? REP_PERIOD_LAST : REP_DELAY_LAST));
`else
   logic repeat_unused;
   assign repeat_unused = (REPEAT_DELAY > REPEAT_PERIOD);
`endif

   // State register plus the registered outputs
   always_ff @(posedge clock) begin
      if (!RST_N) begin
         state      <= IDLE;
         pulse_cnt  <= '0;
         btn_prev   <= 1'b0;
         clr_prev   <= 1'b0;
         MAN_CLK    <= 1'b0;
         STEP_COUNT <= '0;
      end else begin
         state    <= next_state;
         btn_prev <= btn_db;
         clr_prev <= clr_db;
         MAN_CLK  <= man_clk_next;
         if (state == PULSE && next_state == PULSE) pulse_cnt <= pulse_cnt + 1'b1;
         else                                       pulse_cnt <= '0;
         // A clear wins over a coincident increment
         if (clr_rise)      STEP_COUNT <= '0;
         else if (step_inc) STEP_COUNT <= STEP_COUNT + 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      // NOTE: a default is assigned first, so every path through the case
      // assigns next_state and no latch is inferred.
      next_state = state;
      case (state)
         IDLE: begin
            if (press) next_state = gate ? PULSE : WAIT_REL;
         end
         PULSE: begin
            // Mode changes are ignored here, so a started pulse always runs to full width
            if (pulse_cnt == PULSE_LAST) next_state = WAIT_REL;
         end
         WAIT_REL: begin
            if (!btn_db) next_state = IDLE;
`ifdef STEP_REPEAT_EN
            else if (rep_go) next_state = PULSE;
`endif
         end
         default: next_state = IDLE;
      endcase
   end

   // Output logic (feeds the registered outputs)
   always_comb begin
      man_clk_next = (next_state == PULSE);
      step_inc     = (next_state == PULSE) && (state != PULSE);
   end

`ifdef STEP_REPEAT_EN
   always_ff @(posedge clock) begin
      if (!RST_N) begin
         rep_cnt    <= '0;
         rep_stop   <= 1'b0;
         rep_active <= 1'b0;
      end else begin
         if (state == WAIT_REL && next_state == WAIT_REL) rep_cnt <= rep_cnt + 32'd1;
         else                                             rep_cnt <= '0;
         if (state == IDLE) begin
            // A press that was ignored never turns into a repeat
            rep_stop   <= press && !gate;
            rep_active <= 1'b0;
         end else begin
            if (!gate) rep_stop <= 1'b1;
            if (state == WAIT_REL && next_state == PULSE) rep_active <= 1'b1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_front_panel_conditioner.sv
// -----------------------------------------------------------------------------
// tb_front_panel_conditioner
//
// Drives randomized and scripted panel activity into front_panel_conditioner.
// Each clock, all five outputs are compared against a behavioural model. The
// model debounces with a sliding window of the last DEBOUNCE_CYCLES
// synchronized samples. It tracks the step pulse as a count of remaining high
// cycles.
// -----------------------------------------------------------------------------
module tb_front_panel_conditioner;

   localparam int DB = 4;
   localparam int CW = 8;
   localparam int HI = 3;
   localparam int RD = 10;
   localparam int RP = 6;

   logic       clock = 1'b0;
   logic       RST_N = 1'b0;
   logic       RUN_SW = 1'b1, CLR_SW = 1'b1, A_M_SW = 1'b1, STEP_BTN = 1'b1;
   logic       RUN, CLR, A_M, MAN_CLK;
   logic [7:0] STEP_COUNT;

   front_panel_conditioner #(
      .DEBOUNCE_CYCLES (DB),
      .CNT_W           (CW),
      .STEP_HIGH_CYCLES(HI),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clock     (clock),
      .RST_N     (RST_N),
      .RUN_SW    (RUN_SW),
      .CLR_SW    (CLR_SW),
      .A_M_SW    (A_M_SW),
      .STEP_BTN  (STEP_BTN),
      .RUN       (RUN),
      .CLR       (CLR),
      .A_M       (A_M),
      .MAN_CLK   (MAN_CLK),
      .STEP_COUNT(STEP_COUNT)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model. Channel order: 0 RUN, 1 CLR, 2 A_M, 3 STEP_BTN.
   // hist[c][0] is the raw sample from the previous edge, and hist[c][j] the one
   // j edges earlier. The two-flop delay means the debouncer acts on
   // hist[c][DB:1].
   // ---------------------------------------------------------------------------
   bit [DB:0] hist [4];
   bit [3:0]  m_lvl;
   bit        m_btn_prev, m_clr_prev;
   int        m_hi;        // remaining MAN_CLK high cycles
   bit        m_wait;      // waiting for button release
   int        m_cnt;
`ifdef STEP_REPEAT_EN
   int        m_rcnt;
   bit        m_rstop, m_ractive;
`endif

   task automatic model_edge();
      bit [3:0] raw;
      bit gate, btn, press, clr_rise, start;
`ifdef STEP_REPEAT_EN
      bit idle_before;
`endif
      raw = {STEP_BTN, A_M_SW, CLR_SW, RUN_SW};
      if (!RST_N) begin
         for (int c = 0; c < 4; c++) hist[c] = '0;
         m_lvl = '0; m_btn_prev = 0; m_clr_prev = 0;
         m_hi = 0; m_wait = 0; m_cnt = 0;
`ifdef STEP_REPEAT_EN
         m_rcnt = 0; m_rstop = 0; m_ractive = 0;
`endif
         return;
      end
      gate     = m_lvl[2] & m_lvl[0] & ~m_lvl[1];
      btn      = m_lvl[3];
      press    = btn & ~m_btn_prev;
      clr_rise = m_lvl[1] & ~m_clr_prev;
      start    = 0;
`ifdef STEP_REPEAT_EN
      idle_before = (m_hi == 0) && !m_wait;
`endif
      if (m_hi > 0) begin
         m_hi--;
         if (m_hi == 0) begin
            m_wait = 1;
`ifdef STEP_REPEAT_EN
            m_rcnt = 0;
`endif
         end
      end else if (m_wait) begin
         if (!btn) m_wait = 0;
`ifdef STEP_REPEAT_EN
         else if (gate && !m_rstop && m_rcnt == (m_ractive ? RP - HI : RD) - 1) begin
            m_wait = 0; m_hi = HI; start = 1; m_ractive = 1;
         end else m_rcnt++;
`endif
      end else if (press) begin
         if (gate) begin
            m_hi = HI; start = 1;
         end else begin
            m_wait = 1;
`ifdef STEP_REPEAT_EN
            m_rcnt = 0;
`endif
         end
      end
`ifdef STEP_REPEAT_EN
      if (idle_before) begin
         m_rstop = press & ~gate; m_ractive = 0;
      end else if (!gate) m_rstop = 1;
`endif
      if (clr_rise)   m_cnt = 0;
      else if (start) m_cnt = (m_cnt + 1) % 256;
      m_btn_prev = btn;
      m_clr_prev = m_lvl[1];
      for (int c = 0; c < 4; c++) begin
         if (hist[c][DB:1] == {DB{~m_lvl[c]}}) m_lvl[c] = ~m_lvl[c];
         hist[c] = {hist[c][DB-1:0], raw[c]};
      end
   endtask

   task automatic check_all();
      check("RUN", RUN, m_lvl[0]);
      check("CLR", CLR, m_lvl[1]);
      check("A_M", A_M, m_lvl[2]);
      check("MAN_CLK", MAN_CLK, m_hi > 0);
      check("STEP_COUNT", STEP_COUNT, 32'(m_cnt));
   endtask

   // One clock: the model follows the rising edge, and the outputs are checked on the falling edge
   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clock);
         model_edge();
         @(negedge clock);
         check_all();
      end
   endtask

   task automatic press_release(input int hold, input int gap);
      STEP_BTN = 1; tick(hold);
      STEP_BTN = 0; tick(gap);
   endtask

   initial begin
      int base;
      // Reset with every raw input high
      RST_N = 0; tick(2);
      RST_N = 1;
      RUN_SW = 0; CLR_SW = 0; A_M_SW = 0; STEP_BTN = 0;
      tick(12);

      // Debounce: clean rise, then 1-clock and 3-clock glitches
      RUN_SW = 1; tick(8);
      RUN_SW = 0; tick(1); RUN_SW = 1; tick(6);
      RUN_SW = 0; tick(3); RUN_SW = 1; tick(6);

      // Manual step: two presses
      A_M_SW = 1; tick(8);
      press_release(20, 10);
      check("count_after_1", STEP_COUNT, 1);
      press_release(20, 10);
      check("count_after_2", STEP_COUNT, 2);

      // Gating: auto mode ignores the press, and switching to manual mid-press does not pulse
      A_M_SW = 0; tick(8);
      STEP_BTN = 1; tick(10);
      A_M_SW = 1; tick(10);
      STEP_BTN = 0; tick(10);
      check("count_gated", STEP_COUNT, 2);
      press_release(10, 10);
      check("count_repress", STEP_COUNT, 3);

      // A_M drops just as the pulse begins: full-width pulse still expected
      STEP_BTN = 1; tick(1);
      A_M_SW = 0; tick(12);
      STEP_BTN = 0; tick(10);
      A_M_SW = 1; tick(8);

      // Reset in the middle of a pulse
      STEP_BTN = 1;
      for (int i = 0; i < 20 && !(m_hi > 0); i++) tick(1);
      check("pulse_started", MAN_CLK, 1);
      RST_N = 0; tick(1);
      check("man_clk_reset", MAN_CLK, 0);
      RST_N = 1; STEP_BTN = 0; tick(12);
      A_M_SW = 1; RUN_SW = 1; tick(8);

      // Long hold: with auto-repeat enabled this yields a train of pulses
      STEP_BTN = 1; tick(45);
      STEP_BTN = 0; tick(10);

      // Wrap: 260 presses
      base = m_cnt;
      for (int p = 0; p < 260; p++) press_release(8, 8);
      check("wrap_count", STEP_COUNT, 32'((base + 260) % 256));

      // Clear
      CLR_SW = 1; tick(8);
      check("count_cleared", STEP_COUNT, 0);
      CLR_SW = 0; tick(8);

      // Randomized panel activity, mostly in a state that allows stepping
      for (int seg = 0; seg < 600; seg++) begin
         RUN_SW   = ($urandom_range(0, 7) != 0);
         A_M_SW   = ($urandom_range(0, 7) != 0);
         CLR_SW   = ($urandom_range(0, 11) == 0);
         STEP_BTN = $urandom_range(0, 1);
         RST_N    = ($urandom_range(0, 79) != 0);
         if (!RST_N) begin
            tick(1);
            RST_N = 1;
         end
         tick($urandom_range(1, 14));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
